// File: rtl/red_pitaya_sort_pkg.sv
// Shared defaults and FSM state type for the sort-delay block.
package red_pitaya_sort_pkg;

  localparam int SORT_TW_DEF     = 32;
  localparam int SORT_QDEPTH_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } sort_state_e;

endpackage

// File: rtl/red_pitaya_sort_fifo.sv
// Synchronous FIFO holding pending due-timestamps; push and pop may occur in the same cycle.
module red_pitaya_sort_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/red_pitaya_sort_delay.sv
// Delays each rising edge of trig_i by delay_i cycles and emits a pulse_len_i-cycle sort pulse.
// Statistics counters are built only when RED_PITAYA_SORT_STATS_EN is defined.
module red_pitaya_sort_delay
  import red_pitaya_sort_pkg::*;
#(
  parameter int QDEPTH = SORT_QDEPTH_DEF,
  parameter int TW     = SORT_TW_DEF
) (
  input  logic                     adc_clk_i,
  input  logic                     adc_rst_i,
  input  logic                     trig_i,
  input  logic                     enable_i,
  input  logic                     clr_i,
  input  logic [TW-1:0]            delay_i,
  input  logic [TW-1:0]            pulse_len_i,
  output logic                     pulse_o,
  output logic [$clog2(QDEPTH):0]  pending_o,
  output logic                     overflow_o,
  output logic [TW-1:0]            fired_cnt_o,
  output logic [TW-1:0]            dropped_cnt_o
);

  logic [TW-1:0] r_ts;
  logic [TW-1:0] r_remain;
  logic          r_trig_q;
  logic          r_pulse;
  logic          r_overflow;
  sort_state_e   r_state;

  logic [TW-1:0] w_head;
  logic [TW-1:0] w_diff;
  logic          w_full;
  logic          w_empty;
  logic          w_req;
  logic          w_accept;
  logic          w_due;
  logic          w_pop;
  logic          w_push;
  logic          w_drop_full;
  logic          w_fire;

  assign w_req    = trig_i & ~r_trig_q;
  assign w_accept = w_req & enable_i & ~clr_i;

  // Wrap-safe due test: head is due once ts has reached it modulo 2^TW.
  assign w_diff = r_ts - w_head;
  assign w_due  = ~w_diff[TW-1];

  assign w_pop       = ~w_empty & w_due & ~clr_i;
  assign w_push      = w_accept & (~w_full | w_pop);
  assign w_drop_full = w_accept & w_full & ~w_pop;
  assign w_fire      = w_pop & (pulse_len_i != '0);

  red_pitaya_sort_fifo #(
    .DEPTH (QDEPTH),
    .W     (TW)
  ) u_fifo (
    .i_clk   (adc_clk_i),
    .i_rst   (adc_rst_i),
    .i_clr   (clr_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (r_ts + delay_i),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (pending_o)
  );

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_ts       <= '0;
      r_trig_q   <= 1'b1;
      r_state    <= IDLE;
      r_pulse    <= 1'b0;
      r_remain   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ts     <= r_ts + 1'b1;
      r_trig_q <= trig_i;
      if (clr_i) begin
        r_state    <= IDLE;
        r_pulse    <= 1'b0;
        r_remain   <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_drop_full) r_overflow <= 1'b1;
        case (r_state)
          IDLE: begin
            if (w_fire) begin
              r_state  <= PULSE;
              r_pulse  <= 1'b1;
              r_remain <= pulse_len_i;
            end
          end
          PULSE: begin
            // A retrigger reloads the count so the output never dips low.
            if (w_fire) begin
              r_remain <= pulse_len_i;
            end else if (r_remain == TW'(1)) begin
              r_state <= IDLE;
              r_pulse <= 1'b0;
            end else begin
              r_remain <= r_remain - 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_pulse <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pulse_o    = r_pulse;
  assign overflow_o = r_overflow;

`ifdef RED_PITAYA_SORT_STATS_EN
  logic [TW-1:0] r_fired;
  logic [TW-1:0] r_dropped;
  logic          w_drop_zero;
  logic [1:0]    w_drop_inc;

  assign w_drop_zero = w_pop & (pulse_len_i == '0);
  assign w_drop_inc  = {1'b0, w_drop_full} + {1'b0, w_drop_zero};

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i || clr_i) begin
      r_fired   <= '0;
      r_dropped <= '0;
    end else begin
      if (w_fire && (r_fired != '1)) r_fired <= r_fired + 1'b1;
      // ~r_dropped is the headroom left before saturation.
      if (w_drop_inc != 2'd0) begin
        if (~r_dropped < TW'(w_drop_inc)) r_dropped <= '1;
        else                              r_dropped <= r_dropped + TW'(w_drop_inc);
      end
    end
  end

  assign fired_cnt_o   = r_fired;
  assign dropped_cnt_o = r_dropped;
`else
  assign fired_cnt_o   = '0;
  assign dropped_cnt_o = '0;
`endif

endmodule

// File: tb/tb_red_pitaya_sort_delay.sv
// Directed bench for red_pitaya_sort_delay: a 32-bit main instance and an 8-bit instance for timer wrap.
module tb_red_pitaya_sort_delay;

`ifdef RED_PITAYA_SORT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tb_cyc = 0;
  always @(posedge clk) tb_cyc <= rst ? 0 : tb_cyc + 1;

  // ---------------- DUT signals ----------------
  logic        trig, en, clr;
  logic [31:0] delay, plen;
  logic        pulse;
  logic [3:0]  pending;
  logic        ovf;
  logic [31:0] fired, dropped;

  logic        trig2;
  logic [7:0]  delay2, plen2;
  logic        pulse2;
  logic [2:0]  pending2;
  logic        ovf2;
  logic [7:0]  fired2, dropped2;

  red_pitaya_sort_delay #(.QDEPTH(8), .TW(32)) dut (
    .adc_clk_i     (clk),
    .adc_rst_i     (rst),
    .trig_i        (trig),
    .enable_i      (en),
    .clr_i         (clr),
    .delay_i       (delay),
    .pulse_len_i   (plen),
    .pulse_o       (pulse),
    .pending_o     (pending),
    .overflow_o    (ovf),
    .fired_cnt_o   (fired),
    .dropped_cnt_o (dropped)
  );

  red_pitaya_sort_delay #(.QDEPTH(4), .TW(8)) dut_w (
    .adc_clk_i     (clk),
    .adc_rst_i     (rst),
    .trig_i        (trig2),
    .enable_i      (1'b1),
    .clr_i         (1'b0),
    .delay_i       (delay2),
    .pulse_len_i   (plen2),
    .pulse_o       (pulse2),
    .pending_o     (pending2),
    .overflow_o    (ovf2),
    .fired_cnt_o   (fired2),
    .dropped_cnt_o (dropped2)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] expf_q[$];
  logic [31:0] rise_q[$];
  logic [31:0] fall_q[$];
  logic [31:0] rise2_q[$];
  logic        prev1 = 1'b0;
  logic        prev2 = 1'b0;
  int          peak  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, tb_cyc);
    end
  endtask

  function automatic longint cnt_exp(input longint n);
    return STATS ? n : 0;
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (pulse && !prev1) rise_q.push_back(tb_cyc);
    if (!pulse && prev1) fall_q.push_back(tb_cyc);
    prev1 = pulse;
    if (pulse2 && !prev2) rise2_q.push_back(tb_cyc);
    prev2 = pulse2;
    if (int'(pending) > peak) peak = int'(pending);
  endtask

  task automatic run_until(input int c);
    while (tb_cyc < c) step();
  endtask

  task automatic req_at(input int c, output int k);
    run_until(c);
    trig = 1'b1;
    k    = tb_cyc;
    step();
    trig = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    peak = 0;
  endtask

  task automatic check_edges(input string tag, input int rm, input int fm);
    chk({tag, "_nrise"}, rise_q.size() - rm, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (rm + i < rise_q.size()) chk({tag, "_rise"}, rise_q[rm+i], exp_q[i]);
    chk({tag, "_nfall"}, fall_q.size() - fm, expf_q.size());
    for (int i = 0; i < expf_q.size(); i++)
      if (fm + i < fall_q.size()) chk({tag, "_fall"}, fall_q[fm+i], expf_q[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, k0, k1, k7, rm, fm, rm2;
    int ks[10];
    rst = 1'b1; trig = 1'b1; trig2 = 1'b0; en = 1'b1; clr = 1'b0;
    delay = '0; plen = '0; delay2 = '0; plen2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state; trig held high through reset must not count as a request.
    chk("rst_pulse", pulse, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_fired", fired, 0);
    chk("rst_dropped", dropped, 0);
    repeat (3) step();
    chk("trig_hold_pending", pending, 0);
    trig = 1'b0;
    step();

    // Single request at cycle 10: high 111..160.
    delay = 100; plen = 50;
    rm = rise_q.size(); fm = fall_q.size();
    exp_q.delete(); expf_q.delete();
    req_at(10, k);
    exp_q.push_back(k + 101); expf_q.push_back(k + 151);
    run_until(k + 50);
    chk("single_pending", pending, 1);
    run_until(k + 200);
    check_edges("single", rm, fm);
    chk("single_fired", fired, cnt_exp(1));
    chk("single_pending_end", pending, 0);

    // Timer wrap on 8-bit instance: request at ts=251, delay 20.
    delay2 = 20; plen2 = 5;
    rm2 = rise2_q.size();
    while ((tb_cyc % 256) != 251) step();
    trig2 = 1'b1; k = tb_cyc; step(); trig2 = 1'b0;
    repeat (40) step();
    chk("wrap_nrise", rise2_q.size() - rm2, 1);
    if (rise2_q.size() > rm2) chk("wrap_rise", rise2_q[rm2], k + 21);
    chk("wrap_fired", fired2, cnt_exp(1));

    // Eight requests 10 apart, delay 1000, len 20: retriggers keep the pulse high.
    do_clr();
    delay = 1000; plen = 20;
    rm = rise_q.size(); fm = fall_q.size();
    exp_q.delete(); expf_q.delete();
    k0 = tb_cyc + 5;
    for (int i = 0; i < 8; i++) req_at(k0 + 10*i, ks[i]);
    k7 = ks[7];
    exp_q.push_back(ks[0] + 1001); expf_q.push_back(k7 + 1021);
    run_until(k7 + 1040);
    check_edges("train", rm, fm);
    chk("train_peak", peak, 8);
    chk("train_fired", fired, cnt_exp(8));
    chk("train_ovf", ovf, 0);

    // Ten requests into an 8-deep queue: two dropped.
    do_clr();
    rm = rise_q.size(); fm = fall_q.size();
    exp_q.delete(); expf_q.delete();
    k0 = tb_cyc + 5;
    for (int i = 0; i < 10; i++) req_at(k0 + 4*i, ks[i]);
    chk("ovf_set", ovf, 1);
    chk("ovf_pending", pending, 8);
    exp_q.push_back(ks[0] + 1001); expf_q.push_back(ks[7] + 1021);
    run_until(ks[9] + 1040);
    check_edges("ovf", rm, fm);
    chk("ovf_fired", fired, cnt_exp(8));
    chk("ovf_dropped", dropped, cnt_exp(2));
    chk("ovf_sticky", ovf, 1);
    do_clr();
    chk("clr_ovf", ovf, 0);
    chk("clr_dropped", dropped, 0);

    // Retrigger: delay 10, len 50, two requests 20 apart.
    delay = 10; plen = 50;
    rm = rise_q.size(); fm = fall_q.size();
    exp_q.delete(); expf_q.delete();
    k0 = tb_cyc + 5;
    req_at(k0, k0);
    req_at(k0 + 20, k1);
    exp_q.push_back(k0 + 11); expf_q.push_back(k1 + 61);
    run_until(k1 + 100);
    check_edges("retrig", rm, fm);
    chk("retrig_fired", fired, cnt_exp(2));

    // Zero-length pulse is discarded.
    do_clr();
    delay = 5; plen = 0;
    rm = rise_q.size(); fm = fall_q.size();
    exp_q.delete(); expf_q.delete();
    req_at(tb_cyc + 3, k);
    run_until(k + 20);
    check_edges("zlen", rm, fm);
    chk("zlen_dropped", dropped, cnt_exp(1));
    chk("zlen_fired", fired, 0);
    chk("zlen_pending", pending, 0);

    // Enable low: request ignored.
    en = 1'b0; plen = 5;
    req_at(tb_cyc + 3, k);
    chk("dis_pending", pending, 0);
    en = 1'b1;

    // Zero delay: rise two cycles after the request.
    do_clr();
    delay = 0; plen = 3;
    rm = rise_q.size(); fm = fall_q.size();
    exp_q.delete(); expf_q.delete();
    req_at(tb_cyc + 3, k);
    exp_q.push_back(k + 2); expf_q.push_back(k + 5);
    run_until(k + 20);
    check_edges("d0", rm, fm);

    // Clear mid-pulse with three entries pending.
    do_clr();
    delay = 100; plen = 50;
    rm = rise_q.size(); fm = fall_q.size();
    exp_q.delete(); expf_q.delete();
    k0 = tb_cyc + 5;
    for (int i = 0; i < 4; i++) req_at(k0 + 30*i, ks[i]);
    run_until(ks[0] + 110);
    chk("clr_pre_pulse", pulse, 1);
    chk("clr_pre_pending", pending, 3);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_pulse", pulse, 0);
    chk("clr_pending", pending, 0);
    chk("clr_fired", fired, 0);
    exp_q.push_back(ks[0] + 101); expf_q.push_back(ks[0] + 111);
    repeat (300) step();
    check_edges("clr", rm, fm);

    // Reset mid-pulse with three pending; trig held high across reset.
    rm = rise_q.size(); fm = fall_q.size();
    exp_q.delete(); expf_q.delete();
    k0 = tb_cyc + 5;
    for (int i = 0; i < 4; i++) req_at(k0 + 30*i, ks[i]);
    run_until(ks[0] + 110);
    chk("rst_pre_pending", pending, 3);
    exp_q.push_back(ks[0] + 101); expf_q.push_back(0);
    rst = 1'b1; trig = 1'b1; step(); rst = 1'b0;
    chk("rstm_pulse", pulse, 0);
    chk("rstm_pending", pending, 0);
    repeat (3) step();
    chk("rstm_trig_hold", pending, 0);
    trig = 1'b0;
    repeat (300) step();
    check_edges("rstm", rm, fm);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", tb_cyc);
    $fatal(1, "watchdog");
  end

endmodule
